// File: rtl/dice_scorer.sv
// Game-state tracker for the electronic dice: captures the settled face on each
// button release and maintains histogram, running total, doubles and game-over.
module dice_scorer #(
  parameter int MIN_HOLD = 4,
  parameter int CNT_W    = 8,
  parameter int TOTAL_W  = 10,
  parameter int TARGET   = 20
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               button,
  input  logic [2:0]         throw,
  input  logic [2:0]         sel,
  output logic [2:0]         result,
  output logic               result_valid,
  output logic               double,
  output logic               short_roll,
  output logic               error,
  output logic [TOTAL_W-1:0] total,
  output logic [CNT_W-1:0]   sel_count,
  output logic               game_over
);

  // state   | meaning
  // IDLE    | button low, waiting for a press
  // ROLLING | button held, counting hold cycles
  // DONE    | target reached, inputs ignored until rst
  typedef enum logic [1:0] {IDLE, ROLLING, DONE} state_t;

  localparam int                 HW  = $clog2(MIN_HOLD + 1);
  localparam logic [HW-1:0]      HMX = HW'(MIN_HOLD);
  localparam logic [TOTAL_W-1:0] TGT = TOTAL_W'(TARGET);

  state_t             state;
  logic [HW-1:0]      hold_cnt;
  logic [CNT_W-1:0]   count [0:7];
  logic [TOTAL_W:0]   sum_raw;
  logic [TOTAL_W-1:0] sum_sat;
  logic               face_ok;

  assign sum_raw = {1'b0, total} + (TOTAL_W + 1)'(throw);
  assign sum_sat = sum_raw[TOTAL_W] ? '1 : sum_raw[TOTAL_W-1:0];
  assign face_ok = (throw != 3'd0) && (throw != 3'd7);

  // Entries 0 and 7 are never written, so they stay at zero.
  always_comb begin
    sel_count = '0;
    if (sel != 3'd0 && sel != 3'd7) sel_count = count[sel];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      hold_cnt     <= '0;
      result       <= '0;
      result_valid <= 1'b0;
      double       <= 1'b0;
      short_roll   <= 1'b0;
      error        <= 1'b0;
      total        <= '0;
      game_over    <= 1'b0;
      for (int i = 0; i < 8; i++) count[i] <= '0;
    end else begin
      result_valid <= 1'b0;
      short_roll   <= 1'b0;
      error        <= 1'b0;
      case (state)
        IDLE: begin
          if (button) begin
            state    <= ROLLING;
            hold_cnt <= HW'(1);
          end
        end
        ROLLING: begin
          if (button) begin
            if (hold_cnt != HMX) hold_cnt <= hold_cnt + HW'(1);
          end else begin
            state    <= IDLE;
            hold_cnt <= '0;
            if (hold_cnt < HMX) begin
              short_roll <= 1'b1;
            end else if (!face_ok) begin
              error <= 1'b1;
            end else begin
              // result still holds the previous accepted face (0 after reset)
              double       <= (throw == result);
              result       <= throw;
              result_valid <= 1'b1;
              total        <= sum_sat;
              if (count[throw] != '1) count[throw] <= count[throw] + CNT_W'(1);
              if (sum_sat >= TGT) begin
                game_over <= 1'b1;
                state     <= DONE;
              end
            end
          end
        end
        default: state <= DONE;
      endcase
    end
  end

endmodule

// File: doc/dice_scorer.md
# dice_scorer

Downstream consumer of the electronic dice. Watches the same `button` that drives the dice and the dice's `throw` bus. On each button release it captures the settled face value, validates it, and updates the game state: per-face histogram, running total, doubles flag and game-over detection. Sits between the dice and the board display/LED logic.

## Interface
- `MIN_HOLD`, default 4: minimum number of consecutive button-high cycles for a roll to count.
- `CNT_W`, default 8: width of each per-face histogram counter.
- `TOTAL_W`, default 10: width of the running total.
- `TARGET`, default 20: total at or above which the game ends.

Ports:
- `clk` in 1: clock.
- `rst` in 1: reset, synchronous, active-high.
- `button` in 1: same signal as the dice button input, already synchronous to `clk`.
- `throw` in 3: dice output; legal values are 1..6.
- `sel` in 3: face select (1..6) for the histogram read port.
- `result` out 3: last accepted face value; 0 until the first accepted roll.
- `result_valid` out 1: one-cycle pulse when `result` is updated.
- `double` out 1: high while the last accepted result equals the one before it.
- `short_roll` out 1: one-cycle pulse when a press shorter than `MIN_HOLD` is discarded.
- `error` out 1: one-cycle pulse when a captured `throw` is 0 or 7.
- `total` out TOTAL_W: sum of accepted results; saturates at 2^TOTAL_W-1.
- `sel_count` out CNT_W: histogram count for face `sel`, combinational read; 0 when `sel` is 0 or 7.
- `game_over` out 1: high from reaching `TARGET` until `rst`.

## Operation
- States: IDLE, ROLLING, DONE.
  - IDLE, `button`=1: go to ROLLING, set `hold_cnt`=1.
  - ROLLING, `button`=1: `hold_cnt`++, saturating at `MIN_HOLD`.
  - ROLLING, `button`=0 (release edge): return to IDLE and evaluate the roll.
  - DONE: absorbing until `rst`; the button is ignored and no pulses are generated.
- Evaluation at the release edge, using `throw` sampled on that edge (the dice does not advance on it):
  - `hold_cnt` < `MIN_HOLD`: pulse `short_roll`; nothing else changes.
  - `throw` is 0 or 7: pulse `error`; nothing else changes, including the double history.
  - Otherwise (accept):
    - `result`=`throw`; pulse `result_valid`.
    - `count[throw]`++, saturating at 2^CNT_W-1.
    - `total` += `throw`, saturating.
    - `double`=(`throw`==previous accepted value); there is no double on the first accepted roll after reset.
    - If the new `total` ≥ `TARGET`: assert `game_over` and go to DONE.
- Evaluation outcomes are mutually exclusive. `short_roll` takes priority over `error`.
- `double` holds its value until the next accepted roll.

## Timing
- Reset (`rst`=1 on a rising edge) drives every output and internal register to 0, and the state to IDLE. `rst` overrides any simultaneous release or press.
- Release-to-output latency is 1 cycle. `result`, `result_valid`, `total`, histogram counts, `double`, `game_over`, `short_roll` and `error` all update on the release edge and are visible in the following cycle.
- `result_valid`, `short_roll` and `error` are high for exactly one cycle per release.
- A one-cycle low between presses is enough:
  - The release edge evaluates the roll.
  - The next high edge starts a new ROLLING phase.
- `sel_count` follows `sel` combinationally and reflects the registered counts.
- `game_over` rises in the same cycle as the `result_valid` of the roll that reached `TARGET`.
- Presses already under way when DONE is entered are never evaluated.

## Test plan
- Reset: assert `rst` for 2 cycles with `button`=1 → all outputs 0, state IDLE; then 6 cycles of `button`=1 with the real dice followed by release (`throw` reaches 1+6 → wrap → 1) → `result`=1, `result_valid` one cycle, `total`=1.
- Short press, `button` high for 3 cycles with `throw`=4 → `short_roll` pulse only; `total`, `result` and counts unchanged.
- Doubles, driving `throw` directly: accepted rolls 3, 3, 5 → `double` reads 0, 1, 0; `sel`=3 gives `sel_count`=2; `total`=11.
- Invalid value: release with `throw`=7 → `error` pulse, no `result_valid`. Then accept 2 → `double`=0, `total` +2.
- Game over with `TARGET`=20: accept 6, 6, 6, 2 → `game_over` rises with the 4th `result_valid`, `total`=20. A further press/release gives no pulses. Then `rst` → all outputs 0.
- Saturation with `CNT_W`=2: accept face 5 four times → `sel_count` for 5 stays at 3. Separately, assert `rst` on the same edge as a release → no pulse, all outputs 0.
